// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the mux_2to1 selector and its switch counter.
package mux_pkg;

   localparam int MUX_WIDTH_DEF = 1;
   localparam int MUX_CNT_W_DEF = 8;

   // All-ones value for a counter of the given width; 64-bit so CNT_W=32 still fits.
   function automatic logic [63:0] mux_cnt_max(input int cnt_w);
      return (64'd1 << cnt_w) - 64'd1;
   endfunction

endpackage

// File: rtl/mux_switch_counter.sv
// Saturating count of select changes, detected as sel differing from its registered copy.
module mux_switch_counter
   import mux_pkg::*;
#(
   parameter int CNT_W = MUX_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             sel_q,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(mux_cnt_max(CNT_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if ((sel != sel_q) && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mux_2to1.sv
// Two-input selector with registered observation copies of the output and select.
// Define MUX_SWITCH_CNT_EN to include the saturating select-switch counter; otherwise switch_cnt is 0.
module mux_2to1
   import mux_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH_DEF,
   parameter int CNT_W = MUX_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             sel,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             sel_q,
   output logic [CNT_W-1:0] switch_cnt
);

   // The conditional operator merges matching bits of I0/I1 when sel is X.
   assign out = sel ? I1 : I0;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         sel_q <= 1'b0;
      end else begin
         out_q <= out;
         sel_q <= sel;
      end
   end

`ifdef MUX_SWITCH_CNT_EN
   mux_switch_counter #(
      .CNT_W (CNT_W)
   ) u_switch_counter (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .sel_q (sel_q),
      .cnt   (switch_cnt)
   );
`else
   assign switch_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: truth table, registered path, async reset,
// counter saturation (CNT_W=2) and randomized 8-bit traffic against a reference model.
module tb_mux_2to1;

`ifdef MUX_SWITCH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   // Narrow instance: WIDTH=1, CNT_W=2
   logic       a1, b1, s1;
   logic       o1, oq1, sq1;
   logic [1:0] c1;

   // Wide instance: WIDTH=8, CNT_W=8
   logic [7:0] a8, b8;
   logic       s8;
   logic [7:0] o8, oq8;
   logic       sq8;
   logic [7:0] c8;

   int tests = 0;
   int fails = 0;

   // Reference state: number of select changes seen since reset and last sampled select.
   int   sw1, sw8;
   logic last1, last8;
   logic       eq1;
   logic [7:0] eq8;

   always #10 clk = ~clk;

   mux_2to1 #(.WIDTH(1), .CNT_W(2)) u_w1 (
      .clk(clk), .rst(rst), .I0(a1), .I1(b1), .sel(s1),
      .out(o1), .out_q(oq1), .sel_q(sq1), .switch_cnt(c1)
   );

   mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_w8 (
      .clk(clk), .rst(rst), .I0(a8), .I1(b8), .sel(s8),
      .out(o8), .out_q(oq8), .sel_q(sq8), .switch_cnt(c8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_cnt(input int switches, input int max);
      if (!CNT_EN) return 0;
      return (switches > max) ? max : switches;
   endfunction

   function automatic logic [7:0] pick(input logic [7:0] i0, input logic [7:0] i1, input logic s);
      return (s == 1'b1) ? i1 : i0;
   endfunction

   task automatic model_reset();
      sw1 = 0; sw8 = 0; last1 = 1'b0; last8 = 1'b0; eq1 = 1'b0; eq8 = '0;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic tick();
      #1;
      check("out_w1", 32'(o1), 32'(pick(8'(a1), 8'(b1), s1) & 8'h01));
      check("out_w8", 32'(o8), 32'(pick(a8, b8, s8)));
      eq1 = pick(8'(a1), 8'(b1), s1) & 8'h01;
      eq8 = pick(a8, b8, s8);
      if (s1 != last1) sw1++;
      if (s8 != last8) sw8++;
      last1 = s1;
      last8 = s8;
      @(posedge clk);
      #1;
      check("out_q_w1", 32'(oq1), 32'(eq1));
      check("sel_q_w1", 32'(sq1), 32'(last1));
      check("cnt_w1", 32'(c1), 32'(exp_cnt(sw1, 3)));
      check("out_q_w8", 32'(oq8), 32'(eq8));
      check("sel_q_w8", 32'(sq8), 32'(last8));
      check("cnt_w8", 32'(c8), 32'(exp_cnt(sw8, 255)));
      @(negedge clk);
   endtask

   initial begin
      logic [2:0] tt_in [6];
      logic       tt_out [6];
      tt_in[0] = 3'b000; tt_out[0] = 1'b0;   // {sel, I1, I0}
      tt_in[1] = 3'b001; tt_out[1] = 1'b1;
      tt_in[2] = 3'b010; tt_out[2] = 1'b0;
      tt_in[3] = 3'b100; tt_out[3] = 1'b0;
      tt_in[4] = 3'b101; tt_out[4] = 1'b0;
      tt_in[5] = 3'b110; tt_out[5] = 1'b1;

      rst = 1'b1;
      a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
      a8 = '0;   b8 = '0;   s8 = 1'b0;
      model_reset();

      #5;
      check("rst_out_q_w1", 32'(oq1), 0);
      check("rst_sel_q_w1", 32'(sq1), 0);
      check("rst_cnt_w1", 32'(c1), 0);
      check("rst_out_q_w8", 32'(oq8), 0);
      check("rst_cnt_w8", 32'(c8), 0);

      // Truth table while reset is held: out must keep working.
      for (int i = 0; i < 6; i++) begin
         {s1, b1, a1} = tt_in[i];
         #1;
         check($sformatf("tt%0d", i), 32'(o1), 32'(tt_out[i]));
         #19;
      end
      check("rst_hold_out_q", 32'(oq1), 0);
      check("rst_hold_sel_q", 32'(sq1), 0);
      check("rst_hold_cnt", 32'(c1), 0);

      @(negedge clk);
      a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
      rst = 1'b0;

      // Registered path, then build up a count of 3 with out_q=1.
      a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; tick();
      a1 = 1'b1; b1 = 1'b0; s1 = 1'b1; tick();
      a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; tick();
      a1 = 1'b1; b1 = 1'b1; s1 = 1'b1; tick();

      // Asynchronous reset between edges.
      #2;
      rst = 1'b1;
      #1;
      check("async_out_q", 32'(oq1), 0);
      check("async_sel_q", 32'(sq1), 0);
      check("async_cnt", 32'(c1), 0);
      check("async_out_live", 32'(o1), 1);
      b1 = 1'b0;
      #1;
      check("async_out_track", 32'(o1), 0);
      model_reset();
      @(negedge clk);
      s1 = 1'b0;
      rst = 1'b0;

      // Saturation: 5 toggles -> 1,2,3,3,3 when the counter is built in.
      for (int i = 0; i < 5; i++) begin
         s1 = ~s1;
         a1 = 1'(i);
         b1 = ~a1;
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         s1 = ~s1;
         tick();
      end

      // 8-bit selection and sel=X merge.
      a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0; tick();
      s8 = 1'b1; tick();
      a8 = 8'hFF; b8 = 8'hFF; s8 = 1'bx;
      #1;
      check("xsel_merge", 32'(o8), 32'h000000FF);
      s8 = 1'b1;
      tick();

      // Randomized traffic on both instances.
      for (int i = 0; i < 300; i++) begin
         a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom);
         a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
